// File: rtl/carry_save_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : carry_save_accumulator
// Brief    : Multi-operand accumulator keeping its total in carry-save form;
//            resolves to binary by iterated half-adding after the last operand.
// Revision : 1.0  initial release
// ============================================================================
module carry_save_accumulator #(
  parameter int WORD_WIDTH  = 36,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  out_data,
  output logic                   out_overflow,
  output logic [COUNT_WIDTH-1:0] resolve_cycles
);

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_RESOLVE = 2'd1;
  localparam logic [1:0] ST_OUTPUT  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [WORD_WIDTH-1:0]  sum_q, sum_d;
  logic [WORD_WIDTH-1:0]  carry_q, carry_d;
  logic                   overflow_q, overflow_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   settle_q, settle_d;

  logic [WORD_WIDTH-1:0]  maj;
  logic [WORD_WIDTH-1:0]  half;
  logic                   accept;

  always_comb begin
    accept = in_valid & in_ready;
    maj    = (sum_q & carry_q) | (sum_q & in_data) | (carry_q & in_data);
    half   = sum_q & carry_q;
  end

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    settle_d   = settle_q;

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          sum_d      = sum_q ^ carry_q ^ in_data;
          carry_d    = {maj[WORD_WIDTH-2:0], 1'b0};
          overflow_d = overflow_q | maj[WORD_WIDTH-1];
          if (in_last) begin
            state_d  = ST_RESOLVE;
            settle_d = 1'b1;
          end
        end
      end

      ST_RESOLVE: begin
        // The entry cycle is spent idle so the result appears 2+k cycles after the last accept.
        if (settle_q) begin
          settle_d = 1'b0;
        end else if (carry_q == '0) begin
          state_d = ST_OUTPUT;
        end else begin
          sum_d      = sum_q ^ carry_q;
          carry_d    = {half[WORD_WIDTH-2:0], 1'b0};
          overflow_d = overflow_q | half[WORD_WIDTH-1];
          count_d    = count_q + COUNT_WIDTH'(1);
        end
      end

      ST_OUTPUT: begin
        if (out_ready) begin
          state_d    = ST_ACCUM;
          sum_d      = '0;
          carry_d    = '0;
          overflow_d = 1'b0;
          count_d    = '0;
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= ST_ACCUM;
      sum_q      <= '0;
      carry_q    <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      settle_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      settle_q   <= settle_d;
    end
  end

  assign in_ready       = (state_q == ST_ACCUM) && !clear;
  assign out_valid      = (state_q == ST_OUTPUT) && !clear;
  assign out_data       = sum_q;
  assign out_overflow   = overflow_q;
  assign resolve_cycles = count_q;

endmodule
`default_nettype wire

// File: tb/tb_carry_save_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_carry_save_accumulator
// Brief    : Scoreboard bench; 8-bit instance for directed cases, 36-bit
//            instance for randomised groups.
// Revision : 1.0  initial release
// ============================================================================
module tb_carry_save_accumulator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic clear;
  int   cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // 8-bit instance
  logic       v8, r8, l8, ov8, ordy8, oo8;
  logic [7:0] d8, od8;
  logic [3:0] rc8;

  // 36-bit instance
  logic        v36, r36, l36, ov36, ordy36, oo36;
  logic [35:0] d36, od36;
  logic [5:0]  rc36;
  logic        rand_on;

  carry_save_accumulator #(.WORD_WIDTH(8), .COUNT_WIDTH(4)) dut8 (
    .clock(clock), .clear(clear), .in_valid(v8), .in_ready(r8), .in_data(d8),
    .in_last(l8), .out_valid(ov8), .out_ready(ordy8), .out_data(od8),
    .out_overflow(oo8), .resolve_cycles(rc8)
  );

  carry_save_accumulator #(.WORD_WIDTH(36), .COUNT_WIDTH(6)) dut36 (
    .clock(clock), .clear(clear), .in_valid(v36), .in_ready(r36), .in_data(d36),
    .in_last(l36), .out_valid(ov36), .out_ready(ordy36), .out_data(od36),
    .out_overflow(oo36), .resolve_cycles(rc36)
  );

  typedef struct {
    logic [63:0] data;
    logic        ovf;
    int          cycles;
    bit          chk_cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q36[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Result monitors: compare against the scoreboard head every valid cycle,
  // which also covers output stability under backpressure.
  always @(negedge clock) begin
    if (!clear && ov8) begin
      if (q8.size() == 0) begin
        check("dut8 unexpected result", 64'd1, 64'd0);
      end else begin
        check("dut8 out_data", {56'd0, od8}, q8[0].data);
        check("dut8 out_overflow", {63'd0, oo8}, {63'd0, q8[0].ovf});
        if (q8[0].chk_cyc) check("dut8 resolve_cycles", {60'd0, rc8}, 64'(q8[0].cycles));
        check("dut8 in_ready while out_valid", {63'd0, r8}, 64'd0);
        if (ordy8) void'(q8.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (!clear && ov36) begin
      if (q36.size() == 0) begin
        check("dut36 unexpected result", 64'd1, 64'd0);
      end else begin
        check("dut36 out_data", {28'd0, od36}, q36[0].data);
        check("dut36 out_overflow", {63'd0, oo36}, {63'd0, q36[0].ovf});
        check("dut36 resolve_cycles<=36", {63'd0, (rc36 <= 6'd36)}, 64'd1);
        if (ordy36) void'(q36.pop_front());
      end
    end
  end

  initial begin
    ordy36 = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      ordy36 = rand_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic void push8(input int data, input logic ovf, input int cycles, input bit chk);
    exp_t e;
    e.data = 64'(data); e.ovf = ovf; e.cycles = cycles; e.chk_cyc = chk;
    q8.push_back(e);
  endfunction

  // All driving tasks begin and end at posedge+1.
  task automatic send8(input logic [7:0] d, input logic last, output int t_acc);
    int n = 0;
    v8 = 1'b1; d8 = d; l8 = last;
    @(negedge clock);
    while (!r8 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("dut8 accept timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1;
    t_acc = cyc;
    v8 = 1'b0;
  endtask

  task automatic send36(input logic [35:0] d, input logic last);
    int n = 0;
    v36 = 1'b1; d36 = d; l36 = last;
    @(negedge clock);
    while (!r36 && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) check("dut36 accept timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1;
    v36 = 1'b0;
  endtask

  task automatic wait_valid8(input int t_acc, output int lat);
    int n = 0;
    @(negedge clock);
    while (!ov8 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("dut8 out_valid timeout", 64'd0, 64'd1);
    lat = cyc - t_acc;
    @(posedge clock);
    #1;
  endtask

  task automatic run_group36(input int nops);
    logic [63:0] sum = 64'd0;
    logic [35:0] d;
    exp_t        e;
    for (int i = 0; i < nops; i++) begin
      d   = {4'($urandom_range(0, 15)), 32'($urandom)};
      sum = sum + {28'd0, d};
      if (i == nops - 1) begin
        e.data = {28'd0, sum[35:0]}; e.ovf = (sum >= 64'h10_0000_0000);
        e.cycles = 0; e.chk_cyc = 1'b0;
        q36.push_back(e);
      end
      send36(d, i == nops - 1);
    end
  endtask

  task automatic run_pair36(input logic [35:0] a, input logic [35:0] b);
    logic [63:0] sum;
    exp_t        e;
    sum = {28'd0, a} + {28'd0, b};
    e.data = {28'd0, sum[35:0]}; e.ovf = (sum >= 64'h10_0000_0000);
    e.cycles = 0; e.chk_cyc = 1'b0;
    q36.push_back(e);
    send36(a, 1'b0);
    send36(b, 1'b1);
  endtask

  initial begin
    int t, lat, n;
    clear = 1'b1; rand_on = 1'b0;
    v8 = 1'b0; d8 = '0; l8 = 1'b0; ordy8 = 1'b1;
    v36 = 1'b0; d36 = '0; l36 = 1'b0;

    // Reset behaviour
    @(negedge clock);
    check("in_ready during clear", {63'd0, r8}, 64'd0);
    check("out_valid during clear", {63'd0, ov8}, 64'd0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    check("in_ready after reset", {63'd0, r8}, 64'd1);
    check("out_data after reset", {56'd0, od8}, 64'd0);
    check("resolve_cycles after reset", {60'd0, rc8}, 64'd0);
    check("out_overflow after reset", {63'd0, oo8}, 64'd0);
    @(posedge clock);
    #1;

    // 3 + 5 = 8, three half-add iterations
    send8(8'd3, 1'b0, t);
    push8(8, 1'b0, 3, 1'b1);
    send8(8'd5, 1'b1, t);
    wait_valid8(t, lat);
    check("latency 3+5", 64'(lat), 64'd5);

    // 255 + 1 wraps to 0 with overflow
    send8(8'd255, 1'b0, t);
    push8(0, 1'b1, 7, 1'b1);
    send8(8'd1, 1'b1, t);
    wait_valid8(t, lat);

    // Single operand
    push8(42, 1'b0, 0, 1'b1);
    send8(8'h2A, 1'b1, t);
    wait_valid8(t, lat);
    check("latency single", 64'(lat), 64'd2);

    // Back-to-back groups with a stalled first result
    ordy8 = 1'b0;
    send8(8'd1, 1'b0, t);
    send8(8'd2, 1'b0, t);
    push8(6, 1'b0, 0, 1'b0);
    send8(8'd3, 1'b1, t);
    v8 = 1'b1; d8 = 8'd99; l8 = 1'b1;
    @(negedge clock);
    check("in_ready in RESOLVE", {63'd0, r8}, 64'd0);
    @(posedge clock);
    #1;
    v8 = 1'b0;
    wait_valid8(t, lat);
    for (int i = 0; i < 3; i++) begin
      v8 = ~v8; d8 = 8'd77; l8 = 1'b1;
      @(posedge clock);
      #1;
    end
    v8 = 1'b0;
    ordy8 = 1'b1;
    send8(8'd100, 1'b0, t);
    send8(8'd100, 1'b0, t);
    push8(44, 1'b1, 0, 1'b0);
    send8(8'd100, 1'b1, t);
    push8(7, 1'b0, 0, 1'b1);
    send8(8'd7, 1'b1, t);
    wait_valid8(t, lat);

    // clear in the middle of RESOLVE discards the group
    send8(8'd255, 1'b0, t);
    send8(8'd255, 1'b1, t);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    check("in_ready after mid-resolve clear", {63'd0, r8}, 64'd1);
    check("out_valid after mid-resolve clear", {63'd0, ov8}, 64'd0);
    @(posedge clock);
    #1;
    push8(4, 1'b0, 0, 1'b1);
    send8(8'd4, 1'b1, t);
    wait_valid8(t, lat);

    // Randomised 36-bit groups under random backpressure, plus overflow boundaries
    rand_on = 1'b1;
    run_pair36(36'hF_FFFF_FFFF, 36'd1);
    run_pair36(36'hF_FFFF_FFFE, 36'd1);
    for (int g = 0; g < 25; g++) run_group36($urandom_range(1, 16));

    n = 0;
    while ((q8.size() != 0 || q36.size() != 0) && n < 2000) begin
      @(posedge clock);
      n++;
    end
    check("dut8 scoreboard drained", 64'(q8.size()), 64'd0);
    check("dut36 scoreboard drained", 64'(q36.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
